// File: rtl/uart_transmitter_fpga_status.sv
// uart_transmitter_fpga_status: FIFO-buffered 8-bit UART transmitter for FPGA status/readback bytes
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte push handshake into the FIFO (in_ready = !full)
//   tx              registered serial line, idle high, LSB first
//   busy            frame on the line or FIFO non-empty
//   tx_done         one-cycle pulse on the last clock of each frame's final stop bit
//   fifo_count      FIFO occupancy
//   byte_count      frames fully sent, wraps at 16 bits
// Optional macro UART_TX_PARITY_EN adds parameter PARITY_ODD and a parity bit after the data bits.
module uart_transmitter_fpga_status #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 100000000,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   byte_count
);
  localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic          r_stop, w_stop_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_tx, w_tx_n;
  logic [15:0]   r_byte_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_push, w_pop, w_empty, w_full, w_tick, w_last_stop;
  logic [7:0]    w_head;
`ifdef UART_TX_PARITY_EN
  logic          r_par, w_par_n;
`endif
  assign w_empty     = r_count == '0;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_push      = in_valid && !w_full;
  assign w_head      = r_mem[r_rd];
  assign w_tick      = r_cnt == '0;
  // final clock of the last stop bit: the frame completes on the following edge
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_stop == 1'(STOP_BITS - 1));
  assign in_ready    = !w_full;
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign tx_done     = w_last_stop;
  assign fifo_count  = r_count;
  assign byte_count  = r_byte_count;
  always_comb begin
    w_state_n = r_state;
    // the counter idles at BAUD_DIV-1 so a freshly started bit lasts exactly BAUD_DIV clocks
    w_cnt_n   = (r_state == S_IDLE || w_tick) ? CW'(BAUD_DIV - 1) : r_cnt - CW'(1);
    w_bit_n   = r_bit;
    w_stop_n  = r_stop;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_tx_n    = 1'b0;
          w_state_n = S_START;
`ifdef UART_TX_PARITY_EN
          w_par_n   = ^w_head;
`endif
        end
      end
      S_START: if (w_tick) begin
        w_tx_n    = r_shift[0];
        w_bit_n   = 3'd0;
        w_state_n = S_DATA;
      end
      S_DATA: if (w_tick) begin
        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_tx_n    = r_par ^ PARITY_ODD;
          w_state_n = S_PARITY;
`else
          w_tx_n    = 1'b1;
          w_stop_n  = 1'b0;
          w_state_n = S_STOP;
`endif
        end else begin
          w_bit_n   = r_bit + 3'd1;
          w_shift_n = r_shift >> 1;
          w_tx_n    = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) begin
        w_tx_n    = 1'b1;
        w_stop_n  = 1'b0;
        w_state_n = S_STOP;
      end
`endif
      S_STOP: if (w_tick) begin
        if (w_last_stop) begin
          w_state_n = S_IDLE;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_tx_n    = 1'b0;
            w_state_n = S_START;
`ifdef UART_TX_PARITY_EN
            w_par_n   = ^w_head;
`endif
          end
        end else begin
          w_stop_n = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= CW'(BAUD_DIV - 1);
      r_bit        <= 3'd0;
      r_stop       <= 1'b0;
      r_shift      <= 8'd0;
      r_tx         <= 1'b1;
      r_byte_count <= 16'd0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_bit        <= w_bit_n;
      r_stop       <= w_stop_n;
      r_shift      <= w_shift_n;
      r_tx         <= w_tx_n;
      r_byte_count <= w_last_stop ? r_byte_count + 16'd1 : r_byte_count;
      r_wr         <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd         <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count      <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) r_par <= 1'b0;
    else r_par <= w_par_n;
  end
`endif
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_data;
  end
endmodule

// File: tb/tb_uart_transmitter_fpga_status.sv
// tb_uart_transmitter_fpga_status: scoreboard bench decoding tx frames against queued expected bytes
module tb_uart_transmitter_fpga_status;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 10;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, tx, busy, tx_done;
  logic [4:0]  fifo_count;
  logic [15:0] byte_count;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, done_cnt = 0;
  bit          saw_full = 1'b0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  uart_transmitter_fpga_status #(
    .BAUD_RATE(100000), .CLOCK_FREQ(1000000), .FIFO_DEPTH(16), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count), .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask
  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 5000);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  initial begin : monitor
    bit active;
    int n;
    logic [NB-1:0] fb;
    logic [7:0] e;
    active = 1'b0;
    n = 0;
    fb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (tx_done) done_cnt++;
        if (fifo_count == 5'd16) saw_full = 1'b1;
        if (in_ready !== (fifo_count != 5'd16)) chk("in_ready_vs_count", 32'(in_ready), 32'(fifo_count != 5'd16));
        if (!active && tx == 1'b0) begin
          active = 1'b1;
          n = 1;
          starts.push_back(cyc);
        end else if (active) begin
          n++;
        end
        if (tx_done !== (active && n == FRAME)) chk("tx_done_timing", 32'(tx_done), 32'(active && n == FRAME));
        if (active) begin
          if (n % 10 == 5) fb[n/10] = tx;
          if (n == FRAME) begin
            active = 1'b0;
            chk("start_bit", 32'(fb[0]), 32'd0);
            chk("stop_bit", 32'(fb[NB-1]), 32'd1);
            if (exp_q.size() == 0) begin
              chk("sb_unexpected_frame", 32'(fb[8:1]), 32'hxx);
            end else begin
              e = exp_q.pop_front();
              chk("frame_data", 32'(fb[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
              chk("parity_bit", 32'(fb[9]), 32'(^e));
`endif
            end
          end
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, w, d0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_state", {tx, busy, in_ready, fifo_count, byte_count}, {1'b1, 1'b0, 1'b1, 5'd0, 16'd0});
    end
    d0 = done_cnt;
    push(8'hA5);
    @(negedge clk);
    chk("a5_not_yet_started", 32'(tx), 32'd1);
    @(negedge clk);
    chk("a5_start_latency", 32'(tx), 32'd0);
    wait_idle();
    chk("a5_byte_count", 32'(byte_count), 32'd1);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_done_pulses", 32'(done_cnt - d0), 32'd1);
    starts.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle();
    chk("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FRAME));
      chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FRAME));
    end
    chk("b2b_byte_count", 32'(byte_count), 32'd4);
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    wait_idle();
    chk("burst_saw_full", 32'(saw_full), 32'd1);
    chk("burst_byte_count", 32'(byte_count), 32'd21);
    chk("burst_sb_drained", 32'(exp_q.size()), 32'd0);
    push(8'h81);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx != 1'b0 && w < 100);
    chk("rst_frame_started", 32'(tx), 32'd0);
    t0 = cyc;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    while (cyc < t0 + 44) @(negedge clk);
    chk("rst_pre_count", 32'(fifo_count), 32'd3);
    d0 = done_cnt;
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (120) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_line_idle", 32'(tx), 32'd1);
    push(8'h5A);
    wait_idle();
    chk("post_rst_byte_count", 32'(byte_count), 32'd1);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
`ifdef UART_TX_PARITY_EN
    push(8'h07);
    wait_idle();
    chk("parity_byte_count", 32'(byte_count), 32'd2);
`endif
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
